arb8_rr_grant_ctrl: RTL and testbench

- Sequential arbiter sharing one resource among 8 requesters.
- Arbitration uses fixed-priority encoding (bit 7 highest) or round-robin.
- Outputs a registered one-hot grant plus its 3-bit index, which drives the shared datapath's select.
- Enforces a maximum hold time per grant, so one requester cannot starve the others.

---
 rtl/arb8_rr_grant_ctrl.sv | 157 +++++++++++++++
 tb/tb_arb8_rr_grant_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arb8_rr_grant_ctrl.sv
// -----------------------------------------------------------------------------
// arb8_rr_grant_ctrl
//
// Shares one resource among 8 requesters. Arbitration is either fixed priority
// (bit 7 highest) or round-robin (previous owner lowest). The grant, its index
// and a valid flag are registered. A grant is preempted after MAX_HOLD cycles,
// and a one-cycle timeout pulse is raised when that happens. Every grant is
// followed by at least one idle cycle with gnt=0.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   en         in   arbitration enable (only consulted while idle)
//   rr_mode    in   1 = round-robin, 0 = fixed priority (sampled while idle)
//   req[7:0]   in   level-sensitive request lines
//   gnt[7:0]   out  one-hot grant, zero when idle
//   gnt_idx    out  index of the granted bit, holds last value when idle
//   gnt_valid  out  high whenever gnt is nonzero
//   timeout    out  one-cycle pulse when a grant is preempted by MAX_HOLD
// -----------------------------------------------------------------------------
module arb8_rr_grant_ctrl #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rr_mode,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO  = HOLD_W'(0);

    logic [0:0]        state_q,     state_d;
    logic [7:0]        gnt_q,       gnt_d;
    logic [2:0]        gnt_idx_q,   gnt_idx_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              timeout_q,   timeout_d;
    logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [2:0]        last_idx_q,  last_idx_d;

    logic [2:0]        start_idx_s;
    logic [2:0]        cand_idx_s;
    logic [2:0]        win_idx_s;
    logic              win_found_s;

    // Winner search: descending from the start index with 3-bit wraparound.
    // In round-robin mode the search starts just below the previous owner, so
    // that owner is visited last; after reset last_idx=0 gives start 7, which
    // is the same as fixed order.
    always_comb begin
        start_idx_s = 3'd7;
        cand_idx_s  = 3'd0;
        win_idx_s   = 3'd0;
        win_found_s = 1'b0;
        if (rr_mode) begin
            start_idx_s = last_idx_q - 3'd1;
        end else begin
            start_idx_s = 3'd7;
        end
        for (int k = 0; k < 8; k++) begin
            cand_idx_s = start_idx_s - 3'(k);
            if (!win_found_s && req[cand_idx_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_idx_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state logic for the IDLE/GRANT FSM, hold counter and outputs.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_idx_d  = last_idx_q;
        case (state_q)
            IDLE: begin
                if (en && win_found_s) begin
                    state_d     = GRANT;
                    gnt_d       = 8'd1 << win_idx_s;
                    gnt_idx_d   = win_idx_s;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = HOLD_ONE;
                    last_idx_d  = win_idx_s;
                end else begin
                    gnt_d       = 8'd0;
                    gnt_valid_d = 1'b0;
                end
            end
            GRANT: begin
                // Release has priority over timeout: an owner that lets go on
                // the last allowed cycle does not get a timeout pulse.
                if (!req[gnt_idx_q]) begin
                    state_d     = IDLE;
                    gnt_d       = 8'd0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = HOLD_ZERO;
                end else if (hold_cnt_q == MAX_HOLD_C) begin
                    state_d     = IDLE;
                    gnt_d       = 8'd0;
                    gnt_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                    hold_cnt_d  = HOLD_ZERO;
                end else begin
                    hold_cnt_d  = hold_cnt_q + HOLD_ONE;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 8'd0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = HOLD_ZERO;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 8'd0;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= HOLD_ZERO;
            last_idx_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            last_idx_q  <= last_idx_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_arb8_rr_grant_ctrl.sv
// -----------------------------------------------------------------------------
// tb_arb8_rr_grant_ctrl
//
// Directed scenarios plus a random stress phase for arb8_rr_grant_ctrl with
// MAX_HOLD=4. Each cycle a reference model predicts the outputs; the
// prediction is queued when the inputs are driven and popped once the DUT
// has clocked. Directed steps add constant expectations, and invariants
// (one-hot, valid, gap cycle, hold bound, requester-only grant) are checked
// every cycle.
// -----------------------------------------------------------------------------
module tb_arb8_rr_grant_ctrl;

    localparam int MAXH = 4;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rr_mode;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    exp_t exp_q[$];

    // reference model state
    logic [7:0] m_gnt   = 8'd0;
    int         m_idx   = 0;
    int         m_last  = 0;
    int         m_hold  = 0;
    logic       m_valid = 1'b0;
    logic       m_to    = 1'b0;

    // invariant tracking
    logic [7:0] prev_gnt = 8'd0;
    int         run_len  = 0;

    arb8_rr_grant_ctrl #(.MAX_HOLD(MAXH), .HOLD_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rr_mode   (rr_mode),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int w;
        m_to = 1'b0;
        if (rst) begin
            m_gnt = 8'd0; m_idx = 0; m_valid = 1'b0; m_hold = 0; m_last = 0;
        end else if (m_valid) begin
            if (!req[m_idx]) begin
                m_valid = 1'b0; m_gnt = 8'd0;
            end else if (m_hold == MAXH) begin
                m_valid = 1'b0; m_gnt = 8'd0; m_to = 1'b1;
            end else begin
                m_hold++;
            end
        end else if (en && (req != 8'd0)) begin
            w = -1;
            for (int i = 1; i <= 8; i++) begin
                int c;
                c = rr_mode ? ((m_last + 8 - i) % 8) : (8 - i);
                if (w < 0 && req[c]) w = c;
            end
            m_idx = w; m_last = w; m_hold = 1; m_valid = 1'b1;
            m_gnt = 8'd1 << w;
        end
    endtask

    // One clock: predict, queue, clock, pop and compare, then invariants.
    task automatic step();
        exp_t e;
        exp_t got;
        logic [7:0] req_at_edge;
        model_step();
        e.gnt = m_gnt; e.idx = m_idx[2:0]; e.valid = m_valid; e.to = m_to;
        exp_q.push_back(e);
        req_at_edge = req;
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check("model_gnt",     32'(gnt),       32'(got.gnt));
        check("model_idx",     32'(gnt_idx),   32'(got.idx));
        check("model_valid",   32'(gnt_valid), 32'(got.valid));
        check("model_timeout", 32'(timeout),   32'(got.to));
        check("inv_onehot",    32'($onehot0(gnt)), 32'd1);
        check("inv_valid",     32'(gnt_valid), 32'(|gnt));
        if (prev_gnt != 8'd0 && gnt != 8'd0) begin
            check("inv_gap", 32'(gnt), 32'(prev_gnt));
        end
        if (prev_gnt == 8'd0 && gnt != 8'd0) begin
            check("inv_req_at_grant", 32'((gnt & req_at_edge) != 8'd0), 32'd1);
        end
        if (gnt != 8'd0 && gnt == prev_gnt) run_len++;
        else run_len = (gnt != 8'd0) ? 1 : 0;
        check("inv_hold_bound", 32'(run_len <= MAXH), 32'd1);
        prev_gnt = gnt;
    endtask

    initial begin
        int ex;
        rst = 1'b1; en = 1'b0; rr_mode = 1'b0; req = 8'd0;

        // reset state
        step();
        step();
        check("rst_gnt",   32'(gnt),       32'h0);
        check("rst_idx",   32'(gnt_idx),   32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        check("rst_to",    32'(timeout),   32'h0);

        // fixed order: 7 wins, drop it, gap, then 2
        rst = 1'b0; en = 1'b1; rr_mode = 1'b0; req = 8'b1000_0101;
        step();
        check("fix_gnt7", 32'(gnt),     32'h80);
        check("fix_idx7", 32'(gnt_idx), 32'd7);
        req = 8'b0000_0101;
        step();
        check("fix_gap", 32'(gnt), 32'h0);
        step();
        check("fix_gnt2", 32'(gnt),     32'h04);
        check("fix_idx2", 32'(gnt_idx), 32'd2);
        req = 8'd0;
        step();
        check("fix_rel", 32'(gnt), 32'h0);

        // round-robin rotation 7..0,7 with 3-cycle grants
        rst = 1'b1;
        step();
        rst = 1'b0; rr_mode = 1'b1;
        for (int g = 0; g < 9; g++) begin
            ex = (15 - g) % 8;
            req = 8'hFF;
            step();
            check("rr_idx", 32'(gnt_idx), 32'(ex));
            check("rr_gnt", 32'(gnt),     32'(8'd1 << ex));
            step();
            step();
            check("rr_hold", 32'(gnt), 32'(8'd1 << ex));
            req = 8'hFF & ~(8'd1 << ex);
            step();
            check("rr_gap", 32'(gnt), 32'h0);
        end
        req = 8'd0;
        step();

        // timeout: 4 cycles held, pulse with gnt=0, then re-grant
        req = 8'h10;
        step();
        check("to_gnt_c1", 32'(gnt), 32'h10);
        step();
        step();
        step();
        check("to_gnt_c4", 32'(gnt),     32'h10);
        check("to_noto_c4", 32'(timeout), 32'd0);
        step();
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_gnt0",  32'(gnt),     32'h0);
        step();
        check("to_pulse_end", 32'(timeout), 32'd0);
        check("to_regrant",   32'(gnt),     32'h10);
        req = 8'd0;
        step();

        // enable gating
        rr_mode = 1'b0; en = 1'b0; req = 8'h22;
        for (int i = 0; i < 5; i++) begin
            step();
            check("en_off", 32'(gnt), 32'h0);
        end
        en = 1'b1;
        step();
        check("en_on_gnt", 32'(gnt),     32'h20);
        check("en_on_idx", 32'(gnt_idx), 32'd5);
        en = 1'b0;
        step();
        step();
        check("en_drop_hold", 32'(gnt), 32'h20);
        req = 8'h02;
        step();
        check("en_rel", 32'(gnt), 32'h0);
        step();
        check("en_stay_idle", 32'(gnt), 32'h0);

        // reset mid-grant, then RR restarts from last_idx=0
        en = 1'b1; req = 8'h08;
        step();
        check("mid_gnt", 32'(gnt), 32'h08);
        rst = 1'b1;
        step();
        check("mid_rst_gnt",   32'(gnt),       32'h0);
        check("mid_rst_valid", 32'(gnt_valid), 32'h0);
        check("mid_rst_to",    32'(timeout),   32'h0);
        rst = 1'b0; rr_mode = 1'b1; req = 8'h09;
        step();
        check("mid_rr_gnt", 32'(gnt), 32'h08);
        req = 8'd0;
        step();

        // random stress
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(3) == 0) req = 8'($urandom);
            en      = ($urandom_range(7) != 0);
            if ($urandom_range(15) == 0) rr_mode = ~rr_mode;
            rst     = ($urandom_range(499) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
